// File: rtl/mux2x1_rr_arbiter.sv
// Two-requester round-robin arbiter feeding a shared 2:1 mux and a one-entry
// valid/ready output register, with per-requester accepted-word counters.
module mux2x1_rr_arbiter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_a,
  input  logic [WIDTH-1:0] a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] b,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic             sel,
  output logic [WIDTH-1:0] y,
  output logic             y_valid,
  input  logic             y_ready,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] y_q, y_d;
  logic             y_valid_q, y_valid_d;
  logic             sel_q, sel_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] cnt_a_q, cnt_a_d;
  logic [CNT_W-1:0] cnt_b_q, cnt_b_d;

  logic             space;
  logic             gnt_a_c;
  logic             gnt_b_c;

  // last_q=1 means B won most recently, so A is preferred on a tie.
  always_comb begin
    space   = !y_valid_q || y_ready;
    gnt_a_c = 1'b0;
    gnt_b_c = 1'b0;
    if (!rst && space) begin
      if (req_a && req_b) begin
        gnt_a_c = last_q;
        gnt_b_c = !last_q;
      end else begin
        gnt_a_c = req_a;
        gnt_b_c = req_b;
      end
    end
  end

  always_comb begin
    y_d       = y_q;
    y_valid_d = y_valid_q;
    sel_d     = sel_q;
    last_d    = last_q;
    cnt_a_d   = cnt_a_q;
    cnt_b_d   = cnt_b_q;
    if (gnt_a_c) begin
      y_d       = a;
      sel_d     = 1'b0;
      last_d    = 1'b0;
      y_valid_d = 1'b1;
      cnt_a_d   = cnt_a_q + CNT_ONE;
    end else if (gnt_b_c) begin
      y_d       = b;
      sel_d     = 1'b1;
      last_d    = 1'b1;
      y_valid_d = 1'b1;
      cnt_b_d   = cnt_b_q + CNT_ONE;
    end else if (y_valid_q && y_ready) begin
      y_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q       <= '0;
      y_valid_q <= 1'b0;
      sel_q     <= 1'b0;
      last_q    <= 1'b1;
      cnt_a_q   <= '0;
      cnt_b_q   <= '0;
    end else begin
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
      sel_q     <= sel_d;
      last_q    <= last_d;
      cnt_a_q   <= cnt_a_d;
      cnt_b_q   <= cnt_b_d;
    end
  end

  assign gnt_a   = gnt_a_c;
  assign gnt_b   = gnt_b_c;
  assign y       = y_q;
  assign y_valid = y_valid_q;
  assign sel     = sel_q;
  assign cnt_a   = cnt_a_q;
  assign cnt_b   = cnt_b_q;

endmodule
